arm_ctrl_issue: RTL

- Next-generation ARM control unit.
- Decodes mode/opcode/S into execute controls, registers them into the ID/EX boundary, and inserts bubbles for hazards and flushes.
- Runs a handshake FSM that stalls the front end while an LDR/STR waits on memory, with an optional timeout.
- Sits between the IF/ID register and the EX stage; replaces the purely combinational control unit.

---
 rtl/arm_ctrl_pkg.sv | 66 ++++++
 rtl/arm_ctrl_issue_decode.sv | 77 +++++++
 rtl/arm_ctrl_issue.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/arm_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// arm_ctrl_pkg
// Shared definitions for the ARM issue-stage control slice:
//   - instruction mode constants (MODE_ALU / MODE_MEM / MODE_BR)
//   - ALU opcode constants and the single LDR/STR opcode
//   - EXE_* ALU command encodings (4 bits, zero-extended at the top level)
//   - issue FSM state enum
//   - ctrl_word_t: the control word carried across the ID/EX boundary
// ----------------------------------------------------------------------------
package arm_ctrl_pkg;

   // Instruction mode field
   localparam logic [1:0] MODE_ALU = 2'b00;
   localparam logic [1:0] MODE_MEM = 2'b01;
   localparam logic [1:0] MODE_BR  = 2'b10;

   // Data-processing opcodes (mode 00)
   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_EOR = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_ADC = 4'b0101;
   localparam logic [3:0] OP_SBC = 4'b0110;
   localparam logic [3:0] OP_TST = 4'b1000;
   localparam logic [3:0] OP_CMP = 4'b1010;
   localparam logic [3:0] OP_ORR = 4'b1100;
   localparam logic [3:0] OP_MOV = 4'b1101;
   localparam logic [3:0] OP_MVN = 4'b1111;

   // The only legal opcode in mode 01; S selects LDR (1) or STR (0)
   localparam logic [3:0] OP_LDST = 4'b0100;

   // ALU command encodings
   localparam logic [3:0] EXE_NOP = 4'b0000;
   localparam logic [3:0] EXE_MOV = 4'b0001;
   localparam logic [3:0] EXE_ADD = 4'b0010;
   localparam logic [3:0] EXE_ADC = 4'b0011;
   localparam logic [3:0] EXE_SUB = 4'b0100;
   localparam logic [3:0] EXE_SBC = 4'b0101;
   localparam logic [3:0] EXE_AND = 4'b0110;
   localparam logic [3:0] EXE_ORR = 4'b0111;
   localparam logic [3:0] EXE_EOR = 4'b1000;
   localparam logic [3:0] EXE_MVN = 4'b1001;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   typedef struct packed {
      logic [3:0] exe_cmd;
      logic       s_update;
      logic       branch;
      logic       mem_w_en;
      logic       mem_r_en;
      logic       wb_en;
   } ctrl_word_t;

   localparam ctrl_word_t CTRL_NOP = '0;

   // A word that touches memory must hold the pipe until mem_ack
   function automatic logic is_mem_op(input ctrl_word_t w);
      return w.mem_r_en | w.mem_w_en;
   endfunction

endpackage

// File: rtl/arm_ctrl_issue_decode.sv
// ----------------------------------------------------------------------------
// arm_ctrl_issue_decode
// Purely combinational decode of mode/opcode/S into an execute control word.
// Ports:
//   mode    in  2   instruction mode field
//   opcode  in  4   instruction opcode field
//   s_in    in  1   instruction S bit
//   word    out     decoded control word (all zero when illegal)
//   illegal out 1   instruction cannot be decoded
// ----------------------------------------------------------------------------
module arm_ctrl_issue_decode
   import arm_ctrl_pkg::*;
(
   input  logic [1:0] mode,
   input  logic [3:0] opcode,
   input  logic       s_in,
   output ctrl_word_t word,
   output logic       illegal
);

   always_comb begin
      word    = CTRL_NOP;
      illegal = 1'b0;
      case (mode)
         MODE_ALU: begin
            word.wb_en    = 1'b1;
            word.s_update = s_in;
            case (opcode)
               OP_MOV: word.exe_cmd = EXE_MOV;
               OP_MVN: word.exe_cmd = EXE_MVN;
               OP_ADD: word.exe_cmd = EXE_ADD;
               OP_ADC: word.exe_cmd = EXE_ADC;
               OP_SUB: word.exe_cmd = EXE_SUB;
               OP_SBC: word.exe_cmd = EXE_SBC;
               OP_AND: word.exe_cmd = EXE_AND;
               OP_ORR: word.exe_cmd = EXE_ORR;
               OP_EOR: word.exe_cmd = EXE_EOR;
               // Compare/test only set flags: no writeback, S forced on
               OP_CMP: begin
                  word.exe_cmd  = EXE_SUB;
                  word.wb_en    = 1'b0;
                  word.s_update = 1'b1;
               end
               OP_TST: begin
                  word.exe_cmd  = EXE_AND;
                  word.wb_en    = 1'b0;
                  word.s_update = 1'b1;
               end
               default: begin
                  word    = CTRL_NOP;
                  illegal = 1'b1;
               end
            endcase
         end
         MODE_MEM: begin
            if (opcode == OP_LDST) begin
               // Address is base + offset for both directions
               word.exe_cmd = EXE_ADD;
               if (s_in) begin
                  word.mem_r_en = 1'b1;
                  word.wb_en    = 1'b1;
               end else begin
                  word.mem_w_en = 1'b1;
               end
            end else begin
               illegal = 1'b1;
            end
         end
         MODE_BR: begin
            word.exe_cmd = EXE_NOP;
            word.branch  = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/arm_ctrl_issue.sv
// ----------------------------------------------------------------------------
// arm_ctrl_issue
// ID/EX control stage: decodes the ID instruction, registers the control word
// into EX (latency 1), inserts bubbles for flush/hazard/illegal, and holds the
// front end while an LDR/STR waits for mem_ack (optional timeout -> mem_err).
//
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to make the first illegal
// instruction set a sticky illegal_trap that bubbles everything and stalls
// the front end until reset. Without it illegal_trap is tied 0.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   instr_valid           ID instruction present
//   mode, opcode, s_in    instruction fields
//   hazard, flush         bubble requests (flush has priority)
//   mem_ack               outstanding memory access completes
//   exe_cmd, s_update, branch, mem_w_en, mem_r_en, wb_en   registered controls
//   ctrl_valid            EX control word valid
//   illegal               one-cycle pulse for an undecodable issued slot
//   stall_out             freeze PC and IF/ID (combinational)
//   mem_req               memory access outstanding
//   mem_err               sticky timeout flag
//   illegal_trap          sticky trap (feature-dependent)
// ----------------------------------------------------------------------------
module arm_ctrl_issue
   import arm_ctrl_pkg::*;
#(
   parameter  int EXE_CMD_W   = 4,
   parameter  int MEM_TIMEOUT = 15,
   localparam int CNT_W       = ($clog2(MEM_TIMEOUT + 1) < 1) ? 1 : $clog2(MEM_TIMEOUT + 1)
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 instr_valid,
   input  logic [1:0]           mode,
   input  logic [3:0]           opcode,
   input  logic                 s_in,
   input  logic                 hazard,
   input  logic                 flush,
   input  logic                 mem_ack,
   output logic [EXE_CMD_W-1:0] exe_cmd,
   output logic                 s_update,
   output logic                 branch,
   output logic                 mem_w_en,
   output logic                 mem_r_en,
   output logic                 wb_en,
   output logic                 ctrl_valid,
   output logic                 illegal,
   output logic                 stall_out,
   output logic                 mem_req,
   output logic                 mem_err,
   output logic                 illegal_trap
);

   ctrl_word_t       dec_word;
   logic             dec_illegal;

   state_t           state_reg,   state_next;
   logic [CNT_W-1:0] cnt_reg,     cnt_next;
   ctrl_word_t       word_reg,    word_next;
   logic             valid_reg,   valid_next;
   logic             illegal_reg, illegal_next;
   logic             mem_req_reg, mem_req_next;
   logic             mem_err_reg, mem_err_next;
   logic             trap_active;
   logic             timeout_hit;

   arm_ctrl_issue_decode u_decode (
      .mode    (mode),
      .opcode  (opcode),
      .s_in    (s_in),
      .word    (dec_word),
      .illegal (dec_illegal)
   );

   // The wait cycle about to complete is the MEM_TIMEOUT-th one
   assign timeout_hit = (MEM_TIMEOUT != 0) && ((int'(cnt_reg) + 1) == MEM_TIMEOUT);

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      word_next    = CTRL_NOP;
      valid_next   = 1'b0;
      illegal_next = 1'b0;
      mem_err_next = mem_err_reg;
      case (state_reg)
         IDLE: begin
            // A trapped core stays put; every slot is a bubble
            if (!trap_active && instr_valid && !flush && !hazard) begin
               if (dec_illegal) begin
                  illegal_next = 1'b1;
               end else begin
                  word_next  = dec_word;
                  valid_next = 1'b1;
                  if (is_mem_op(dec_word)) begin
                     state_next = MEM_WAIT;
                     cnt_next   = '0;
                  end
               end
            end
         end
         MEM_WAIT: begin
            // The access is committed: flush/hazard have no effect here.
            cnt_next = cnt_reg + CNT_W'(1);
            if (mem_ack) begin
               // Ack wins over a coincident timeout
               state_next = IDLE;
            end else if (timeout_hit) begin
               state_next   = IDLE;
               mem_err_next = 1'b1;
            end else begin
               word_next  = word_reg;
               valid_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
      mem_req_next = (state_next == MEM_WAIT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         word_reg    <= CTRL_NOP;
         valid_reg   <= 1'b0;
         illegal_reg <= 1'b0;
         mem_req_reg <= 1'b0;
         mem_err_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         word_reg    <= word_next;
         valid_reg   <= valid_next;
         illegal_reg <= illegal_next;
         mem_req_reg <= mem_req_next;
         mem_err_reg <= mem_err_next;
      end
   end

`ifdef CTRL_ILLEGAL_TRAP_EN
   logic trap_reg;

   // Set on the same edge that launches the first illegal pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trap_reg <= 1'b0;
      end else if (illegal_next) begin
         trap_reg <= 1'b1;
      end
   end

   assign trap_active = trap_reg;
`else
   assign trap_active = 1'b0;
`endif

   assign exe_cmd      = EXE_CMD_W'(word_reg.exe_cmd);
   assign s_update     = word_reg.s_update;
   assign branch       = word_reg.branch;
   assign mem_w_en     = word_reg.mem_w_en;
   assign mem_r_en     = word_reg.mem_r_en;
   assign wb_en        = word_reg.wb_en;
   assign ctrl_valid   = valid_reg;
   assign illegal      = illegal_reg;
   assign mem_req      = mem_req_reg;
   assign mem_err      = mem_err_reg;
   assign illegal_trap = trap_active;
   assign stall_out    = (state_reg == MEM_WAIT) || trap_active;

endmodule
